// File: rtl/fnd_pkg.sv
// fnd_pkg -- shared constants for the six-digit seven-segment scanner.
// Holds the digit count, the all-segments-off pattern and the active-low
// {g,f,e,d,c,b,a} patterns for hex digits 0..F.
package fnd_pkg;

    localparam int NUM_DIGIT = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/fnd_dec.sv
// fnd_dec -- combinational hex to seven-segment decoder.
// Ports:
//   hex : 4-bit hex value to display
//   seg : 7-bit segment pattern {g,f,e,d,c,b,a}, active-low
module fnd_dec
    import fnd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Decode one hex nibble into its active-low segment pattern.
    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/fnd_scan_mux.sv
// fnd_scan_mux -- time-multiplexed driver for a six-digit common-anode
// seven-segment display with tear-free, frame-synchronous updates.
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset
//   i_digits   : six hex digits, digit k at [4k+3:4k], digit 0 rightmost
//   i_dp       : decimal point request per digit (1 = lit)
//   i_blank_lz : leading-zero blanking enable
//   i_load     : single-cycle strobe staging i_digits/i_dp/i_blank_lz
//   o_load_ack : one-cycle pulse when staged data becomes visible
//   o_seg      : segments {g,f,e,d,c,b,a}, active-low
//   o_seg_dp   : decimal point, active-low
//   o_seg_enb  : one-hot active-low digit enable
// New data is staged on i_load and copied into the displayed (shadow)
// registers only at the end of a full scan frame, so a frame never mixes
// old and new digits.
module fnd_scan_mux
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 50000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] i_digits,
    input  logic [5:0]  i_dp,
    input  logic        i_blank_lz,
    input  logic        i_load,
    output logic        o_load_ack,
    output logic [6:0]  o_seg,
    output logic        o_seg_dp,
    output logic [5:0]  o_seg_enb
);

    localparam int         PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGIT - 1);

    logic [PW-1:0] presc_r;
    logic [2:0]    idx_r;
    logic [23:0]   stg_digits_r;
    logic [5:0]    stg_dp_r;
    logic          stg_blank_r;
    logic          pending_r;
    logic [23:0]   shd_digits_r;
    logic [5:0]    shd_dp_r;
    logic          shd_blank_r;

    logic          tick_s;
    logic          frame_s;
    logic          commit_s;
    logic [23:0]   digit_shift_s;
    logic [5:0]    dp_shift_s;
    logic [5:0]    onehot_s;
    logic          blank_s;
    logic [6:0]    dec_seg_s;

    // Slot timing, frame boundary and commit decision.
    always_comb begin
        tick_s   = (presc_r == PRESC_LAST);
        frame_s  = tick_s && (idx_r == IDX_LAST);
        commit_s = frame_s && (i_load || pending_r);
    end

    // Select the current digit; shifting the whole word right leaves the
    // current digit in the low nibble and only digits idx..5 above it, so
    // a zero result means this digit and every more significant one are 0.
    always_comb begin
        digit_shift_s = shd_digits_r >> {idx_r, 2'b00};
        dp_shift_s    = shd_dp_r >> idx_r;
        onehot_s      = 6'b000001 << idx_r;
        blank_s       = shd_blank_r && (idx_r != 3'd0) && (digit_shift_s == 24'd0);
    end

    fnd_dec u_dec (
        .hex (digit_shift_s[3:0]),
        .seg (dec_seg_s)
    );

    // Prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= 3'd0;
        end else if (tick_s) begin
            presc_r <= '0;
            idx_r   <= (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Staging registers and pending flag; the last load before a frame
    // boundary wins, and the boundary itself always clears pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_digits_r <= 24'd0;
            stg_dp_r     <= 6'd0;
            stg_blank_r  <= 1'b0;
            pending_r    <= 1'b0;
        end else begin
            if (i_load) begin
                stg_digits_r <= i_digits;
                stg_dp_r     <= i_dp;
                stg_blank_r  <= i_blank_lz;
            end
            if (frame_s) begin
                pending_r <= 1'b0;
            end else if (i_load) begin
                pending_r <= 1'b1;
            end
        end
    end

    // Shadow registers; a load arriving on the boundary cycle bypasses
    // staging so it is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            shd_digits_r <= 24'd0;
            shd_dp_r     <= 6'd0;
            shd_blank_r  <= 1'b0;
            o_load_ack   <= 1'b0;
        end else begin
            if (commit_s) begin
                shd_digits_r <= i_load ? i_digits   : stg_digits_r;
                shd_dp_r     <= i_load ? i_dp       : stg_dp_r;
                shd_blank_r  <= i_load ? i_blank_lz : stg_blank_r;
            end
            o_load_ack <= commit_s;
        end
    end

    // Registered display outputs for the current index.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_seg_enb <= 6'b111110;
            o_seg     <= SEG_0;
            o_seg_dp  <= 1'b1;
        end else begin
            o_seg_enb <= ~onehot_s;
            o_seg     <= blank_s ? SEG_BLANK : dec_seg_s;
            o_seg_dp  <= ~dp_shift_s[0];
        end
    end

endmodule

// File: doc/fnd_scan_mux.md
FND_SCAN_MUX -- requirements
Module: fnd_scan_mux

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range is 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single 50 MHz clock.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port i_digits, input, 24 bits: six hex digits; digit k is [4k+3:4k], and digit 0 is rightmost.
REQ-005 The block SHALL have port i_dp, input, 6 bits: decimal point request per digit; bit k is for digit k; 1 = lit.
REQ-006 The block SHALL have port i_blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-007 The block SHALL have port i_load, input, 1 bit: single-cycle strobe that stages i_digits, i_dp and i_blank_lz.
REQ-008 The block SHALL have port o_load_ack, output, 1 bit: one-cycle pulse when staged data becomes visible.
REQ-009 The block SHALL have port o_seg, output, 7 bits: {g,f,e,d,c,b,a}, active-low.
REQ-010 The block SHALL have port o_seg_dp, output, 1 bit: decimal point, active-low.
REQ-011 The block SHALL have port o_seg_enb, output, 6 bits: digit enable, one-hot, active-low; bit k selects digit k.

Function
REQ-012 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick is asserted when the count equals SCAN_DIV-1.
REQ-013 The digit index SHALL advance on tick and wrap from 5 to 0. The frame boundary is a tick with index 5.
REQ-014 When i_load=1, the block SHALL write the inputs into the staging registers and set pending. A later i_load before commit SHALL overwrite staging (last wins).
REQ-015 At a frame boundary with pending=1, the block SHALL copy staging to the shadow registers and clear pending.
REQ-016 If i_load coincides with the frame boundary, the block SHALL commit that cycle's inputs directly.
REQ-017 o_load_ack SHALL be high for exactly one cycle, the cycle after each commit. Multiple loads merged into one commit SHALL produce one ack.
REQ-018 The display SHALL use only the shadow registers. Staged data SHALL never appear mid-frame (no tearing).
REQ-019 All outputs SHALL be registered. They SHALL reflect the new index and the shadow contents one cycle after the index changes.
REQ-020 o_seg SHALL be the hex decode of the shadow digit: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
REQ-021 With shadow blank_lz=1, digit k (k>=1) SHALL be blanked (o_seg=0x7F) when shadow digits k..5 are all zero.
REQ-022 Digit 0 SHALL never be blanked.
REQ-023 Blanking SHALL NOT affect o_seg_dp.
REQ-024 o_seg_dp SHALL equal the inverse of shadow dp[index].
REQ-025 o_seg_enb SHALL have exactly one bit low at all times, including during and after reset.

Reset
REQ-026 While rst=1 at a clk edge, the following SHALL be cleared to 0: prescaler, index, staging, shadow digits, shadow dp, shadow blank_lz, pending and o_load_ack.
REQ-027 The reset output values SHALL be: o_seg_enb=6'b111110, o_seg=0x40, o_seg_dp=1.
REQ-028 Reset mid-frame SHALL discard a pending load, and no ack SHALL be issued for it.
REQ-029 i_load asserted during reset SHALL be ignored.

Structure
REQ-030 Package fnd_pkg SHALL hold NUM_DIGIT=6, SEG_BLANK=7'h7F and the 16-entry segment pattern constants.
REQ-031 A combinational sub-module fnd_dec (4-bit hex in, 7-bit active-low segments out) SHALL implement the decode table. The scanner SHALL instantiate it once.

Verification (SCAN_DIV=4 for all scenarios)
REQ-032 Reset: hold rst=1 for 3 cycles -> o_seg_enb=6'b111110, o_seg=0x40, o_seg_dp=1, o_load_ack=0. Then the enable rotates every 4 cycles, showing 0x40 on all digits.
REQ-033 Scan: load 24'h543210 with i_dp=6'b000100 -> after the ack, each step lasts 4 cycles, and the sequence is:
- 111110 / 0x40
- 111101 / 0x79
- 111011 / 0x24 with o_seg_dp=0
- 110111 / 0x30
- 101111 / 0x19
- 011111 / 0x12
REQ-034 Tearing: i_load with 24'hFFFFFF at index 2 -> index 2..5 still show old values; the new value appears from index 0 of the next frame; o_load_ack pulses once, 1 cycle after the boundary.
REQ-035 Merge: load 24'h111111, then 24'h222222 before the boundary -> only 0x24 is ever displayed, and exactly one ack is issued.
REQ-036 Blanking: load 24'h000070 with i_blank_lz=1 -> digits 5..2 show 0x7F, digit 1 shows 0x78, digit 0 shows 0x40. Loading 24'h000000 -> only digit 0 shows 0x40.
REQ-037 Reset mid-frame: i_load, then rst=1 before the boundary -> no ack, shadow stays zero, and the display returns to the reset values.
